// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback types: register address width, data width,
// the writeback request record and the writeback source tag.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU,
    WB_LOAD
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_fifo.sv
// Small synchronous FIFO of writeback requests used as the load-return queue.
// Push on a full FIFO and pop on an empty FIFO are excluded by the caller.
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates the single write port between
// the ALU and a queued load-return path, and keeps a per-register pending
// scoreboard for outstanding loads that drives decode hazard stalls.
module regfile_wb_scheduler
  import rv32i_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            err
);

  localparam int LQ_CW = $clog2(LQ_DEPTH + 1);

  logic [31:1]      pending;
  logic [31:0]      pend_vec;
  logic             src_load;
  logic             ld_accept;
  logic             lq_pop;
  logic             lq_full;
  logic             lq_empty;
  logic [LQ_CW-1:0] lq_count;
  wb_req_t          lq_head;
  wb_req_t          lq_in;
  logic             sel_valid;
  wb_src_e          sel_src;
  wb_req_t          sel_req;

  // x0 has no scoreboard storage; bit 0 is tied low so lookups need no guard.
  assign pend_vec    = {pending, 1'b0};
  assign issue_ready = !pend_vec[issue_rd];
  assign rs1_busy    = pend_vec[rs1_addr];
  assign rs2_busy    = pend_vec[rs2_addr];
  assign ld_ready    = (lq_count != LQ_CW'(LQ_DEPTH));
  assign ld_accept   = ld_valid && ld_ready;
  assign lq_in       = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ld_accept),
    .din   (lq_in),
    .pop   (lq_pop),
    .dout  (lq_head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  // Write-port arbitration: full queue first, then ALU, then queued loads.
  always_comb begin
    alu_ready = 1'b0;
    lq_pop    = 1'b0;
    sel_valid = 1'b0;
    sel_src   = WB_ALU;
    sel_req   = '0;
    if (lq_full) begin
      lq_pop    = 1'b1;
      sel_valid = 1'b1;
      sel_src   = WB_LOAD;
      sel_req   = lq_head;
    end else if (alu_valid && !pend_vec[alu_rd]) begin
      alu_ready = 1'b1;
      sel_valid = 1'b1;
      sel_req   = '{rd: alu_rd, data: alu_data};
    end else if (!lq_empty) begin
      lq_pop    = 1'b1;
      sel_valid = 1'b1;
      sel_src   = WB_LOAD;
      sel_req   = lq_head;
    end
  end

  // Write stage register; a selected x0 write completes without asserting rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      src_load   <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else begin
      rf_we    <= sel_valid && (sel_req.rd != '0);
      src_load <= sel_valid && (sel_src == WB_LOAD);
      if (sel_valid) begin
        rf_rd_addr <= sel_req.rd;
        rf_rd_data <= sel_req.data;
      end
    end
  end

  // Scoreboard: set on accepted load issue, clear when that load is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (rf_we && src_load && (rf_rd_addr == 5'(i)))
          pending[i] <= 1'b0;
        if (issue_valid && issue_ready && (issue_rd == 5'(i)))
          pending[i] <= 1'b1;
      end
    end
  end

  // Sticky error for a load return to a register with no outstanding load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (ld_accept && (ld_rd != '0) && !pend_vec[ld_rd])
      err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a stimulus thread drives inputs,
// checks handshake/hazard outputs against a queue-based model and queues the
// expected register writes; a monitor pops and compares every rf_we write.
module tb_regfile_wb_scheduler;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, alu_valid, ld_valid;
  logic [4:0]  issue_rd, alu_rd, ld_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, ld_data;
  logic        issue_ready, alu_ready, ld_ready, rs1_busy, rs2_busy;
  logic        rf_we, err;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.LQ_DEPTH(LQ_DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .err(err)
  );

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
    int        cyc;
  } wr_t;

  int   checks = 0;
  int   failures = 0;
  int   cycnt = 0;
  wr_t  exp_q[$];
  wr_t  mq[$];
  bit   mpend[32];
  bit   merr;
  bit   clr_v;
  bit [4:0] clr_rd;

  always @(posedge clk) cycnt = cycnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycnt);
    end
  endtask

  function automatic bit mp(input bit [4:0] a);
    return (a != 0) && mpend[a];
  endfunction

  // Monitor: every write must match the oldest expected write, in its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", rf_rd_addr, rf_rd_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write_cycle", cycnt, w.cyc);
          chk("write_addr", {27'd0, rf_rd_addr}, {27'd0, w.rd});
          chk("write_data", rf_rd_data, w.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cycnt) begin
        wr_t w;
        w = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missed_write: got rf_we 0 expected write x%0d=%h", w.rd, w.data);
      end
    end
  end

  // One clock cycle: drive, compare combinational outputs, advance the model.
  task automatic step(input bit iv, input bit [4:0] ird,
                      input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit lv, input bit [4:0] lrd, input bit [31:0] ldt,
                      input bit [4:0] r1, input bit [4:0] r2,
                      output bit ld_acc);
    bit  full, e_ir, e_lr, e_ar, have, isload;
    wr_t w;
    @(posedge clk); #2;
    issue_valid = iv; issue_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldt;
    rs1_addr = r1; rs2_addr = r2;
    #2;
    full = (mq.size() == LQ_DEPTH);
    e_ir = !mp(ird);
    e_lr = !full;
    e_ar = !full && av && !mp(ard);
    chk("issue_ready", issue_ready, e_ir);
    chk("ld_ready", ld_ready, e_lr);
    chk("alu_ready", alu_ready, e_ar);
    chk("rs1_busy", rs1_busy, mp(r1));
    chk("rs2_busy", rs2_busy, mp(r2));
    chk("err", err, merr);
    have = 0; isload = 0; w = '{rd: 0, data: 0, cyc: 0};
    if (full) begin
      w = mq.pop_front(); have = 1; isload = 1;
    end else if (e_ar) begin
      w.rd = ard; w.data = ad; have = 1;
    end else if (mq.size() != 0) begin
      w = mq.pop_front(); have = 1; isload = 1;
    end
    if (lv && e_lr) begin
      if (lrd != 0 && !mpend[lrd]) merr = 1;
      mq.push_back('{rd: lrd, data: ldt, cyc: 0});
    end
    if (have && w.rd != 0) exp_q.push_back('{rd: w.rd, data: w.data, cyc: cycnt + 1});
    if (clr_v) mpend[clr_rd] = 0;
    if (iv && e_ir && ird != 0) mpend[ird] = 1;
    clr_v  = have && isload && (w.rd != 0);
    clr_rd = w.rd;
    ld_acc = lv && e_lr;
  endtask

  task automatic idle(input bit [4:0] r1, input bit [4:0] r2);
    bit a;
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, a);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 0;
    merr = 0; clr_v = 0; clr_rd = 0;
  endtask

  task automatic do_reset(input bit [4:0] r1, input bit [4:0] r2);
    @(posedge clk); #2;
    issue_valid = 0; alu_valid = 0; ld_valid = 0;
    rs1_addr = r1; rs2_addr = r2;
    rst_n = 1'b0;
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd_addr", {27'd0, rf_rd_addr}, 0);
    chk("rst_rf_rd_data", rf_rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    model_clear();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit       acc;
    int       idx;
    bit       hv;
    bit [4:0] hrd;
    bit [31:0] hdata;
    rst_n = 1'b0;
    issue_valid = 0; issue_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; rs1_addr = 0; rs2_addr = 0;
    model_clear();
    do_reset(0, 0);

    // ALU write x5 = DEADBEEF, written the next cycle; scoreboard untouched.
    step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, acc);
    idle(5, 5);

    // Load to x7, return three cycles later, busy observed throughout.
    step(1, 7, 0, 0, 0, 0, 0, 0, 7, 0, acc);
    idle(7, 0);
    idle(7, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'h1234, 7, 0, acc);
    for (int k = 0; k < 4; k++) idle(7, 7);

    // ALU held valid while three loads return back-to-back.
    step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 20, 32'hA000 + k, idx < 3, 5'(10 + idx), 32'hB000 + idx, 10, 12, acc);
      if (acc) idx++;
    end
    for (int k = 0; k < 3; k++) idle(11, 12);

    // WAW stalls on x9 for issue and ALU; x0 accepted with no write.
    step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0, acc);
    step(1, 9, 1, 9, 32'h99, 0, 0, 0, 9, 0, acc);
    step(1, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 1, 9, 32'h9999, 9, 0, acc);
    step(1, 9, 1, 9, 32'h98, 0, 0, 0, 9, 0, acc);
    step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0, acc);
    step(0, 0, 0, 0, 0, 1, 9, 32'h9A, 9, 0, acc);
    for (int k = 0; k < 3; k++) idle(9, 0);

    // Return to x3 with no outstanding load: sticky err, data still written.
    step(0, 0, 0, 0, 0, 1, 3, 32'h3333, 3, 0, acc);
    for (int k = 0; k < 3; k++) idle(3, 0);

    // Reset with x4/x6 pending and their returns sitting in a full queue.
    step(1, 4, 0, 0, 0, 0, 0, 0, 4, 6, acc);
    step(1, 6, 0, 0, 0, 0, 0, 0, 4, 6, acc);
    step(0, 0, 1, 21, 32'hC1, 1, 4, 32'h4444, 4, 6, acc);
    step(0, 0, 1, 21, 32'hC2, 1, 6, 32'h6666, 4, 6, acc);
    do_reset(4, 6);
    step(0, 0, 1, 22, 32'hE1, 0, 0, 0, 4, 6, acc);
    for (int k = 0; k < 3; k++) idle(4, 6);

    // Randomized traffic over a small register window to force collisions.
    hv = 0; hrd = 0; hdata = 0;
    for (int k = 0; k < 500; k++) begin
      if (!hv && $urandom_range(0, 2) == 0) begin
        int start;
        hv = 1; hdata = $urandom;
        hrd = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 9) != 0) begin
          start = $urandom_range(0, 7);
          for (int j = 0; j < 8; j++)
            if (mpend[(start + j) % 8]) hrd = 5'((start + j) % 8);
        end
      end
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           hv, hrd, hdata,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      if (acc) hv = 0;
    end

    // Bounded drain: every queued load and expected write must come out.
    for (int k = 0; k < 20 && (mq.size() != 0 || exp_q.size() != 0); k++) idle(0, 0);
    checks++;
    if (mq.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued / %0d unwritten expected 0", mq.size(), exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
